// File: rtl/channel_hop_sequencer.sv
// Frequency-hopping sequencer: gates an I/Q stream into a modulator and loads a new
// phase increment from a hop table every `dwell` transferred samples.
module channel_hop_sequencer #(
   parameter  int WIDTH       = 16,
   parameter  int PHASE_WIDTH = 12,
   parameter  int NUM_HOPS    = 16,
   parameter  int DWELL_WIDTH = 16,
   localparam int AW          = $clog2(NUM_HOPS)
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic [WIDTH-1:0]       i_inph,
   input  logic [WIDTH-1:0]       i_quad,
   input  logic                   i_valid,
   output logic                   o_ready,
   output logic [WIDTH-1:0]       o_inph,
   output logic [WIDTH-1:0]       o_quad,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [PHASE_WIDTH-1:0] o_phase_inc,
   output logic                   o_phase_inc_valid,
   input  logic                   i_tbl_we,
   input  logic [AW-1:0]          i_tbl_addr,
   input  logic [PHASE_WIDTH-1:0] i_tbl_data,
   input  logic [AW:0]            i_hop_count,
   input  logic [DWELL_WIDTH-1:0] i_dwell,
   input  logic                   i_start,
   input  logic                   i_stop,
   output logic                   o_busy,
   output logic [AW-1:0]          o_hop_index
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t                 state, state_nxt;
   logic [PHASE_WIDTH-1:0] tbl [NUM_HOPS];
   logic [PHASE_WIDTH-1:0] inc_r;
   logic [AW-1:0]          hop, hop_nxt;
   logic [AW:0]            hc_r, hc_in;
   logic [DWELL_WIDTH-1:0] dw_r, dw_in, cnt, cnt_nxt;
   logic                   xfer, hop_done, load_entry;

   // Sanitised sequence parameters, captured on start
   always_comb begin
      hc_in = i_hop_count;
      if (i_hop_count == '0)
         hc_in = (AW+1)'(1);
      else if (i_hop_count > (AW+1)'(NUM_HOPS))
         hc_in = (AW+1)'(NUM_HOPS);
      dw_in = (i_dwell == '0) ? DWELL_WIDTH'(1) : i_dwell;
   end

   assign xfer     = (state == RUN) && i_valid && i_ready;
   assign hop_done = xfer && (cnt == dw_r - 1'b1);

   always_comb begin
      state_nxt  = state;
      hop_nxt    = hop;
      cnt_nxt    = cnt;
      load_entry = 1'b0;
      case (state)
         IDLE: begin
            if (i_start && !i_stop) begin
               state_nxt  = LOAD;
               hop_nxt    = '0;
               cnt_nxt    = '0;
               load_entry = 1'b1;
            end
         end
         LOAD: begin
            state_nxt = RUN;
            if (i_stop) begin
               state_nxt = IDLE;
               hop_nxt   = '0;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            if (i_stop) begin
               state_nxt = IDLE;
               hop_nxt   = '0;
               cnt_nxt   = '0;
            end else if (hop_done) begin
               state_nxt  = LOAD;
               cnt_nxt    = '0;
               hop_nxt    = (({1'b0, hop} + 1'b1) == hc_r) ? '0 : hop + 1'b1;
               load_entry = 1'b1;
            end else if (xfer) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The increment is fetched on the cycle entering LOAD, so it is ready to strobe
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= IDLE;
         hop   <= '0;
         cnt   <= '0;
         inc_r <= '0;
         hc_r  <= (AW+1)'(1);
         dw_r  <= DWELL_WIDTH'(1);
      end else begin
         state <= state_nxt;
         hop   <= hop_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && load_entry) begin
            hc_r <= hc_in;
            dw_r <= dw_in;
         end
         if (load_entry)
            inc_r <= tbl[hop_nxt];
      end
   end

   // Table is not reset; a same-cycle write is seen only on a later read
   always_ff @(posedge i_clock) begin
      if (!i_reset && i_tbl_we)
         tbl[i_tbl_addr] <= i_tbl_data;
   end

   assign o_inph            = i_inph;
   assign o_quad            = i_quad;
   assign o_valid           = !i_reset && (state == RUN) && i_valid;
   assign o_ready           = !i_reset && (state == RUN) && i_ready;
   assign o_phase_inc_valid = !i_reset && (state == LOAD);
   assign o_phase_inc       = i_reset ? '0 : inc_r;
   assign o_busy            = !i_reset && (state != IDLE);
   assign o_hop_index       = i_reset ? '0 : hop;

endmodule

// File: tb/tb_channel_hop_sequencer.sv
// Bench for channel_hop_sequencer: per-cycle comparison against an abstract hop model,
// plus directed scenarios with hand-computed strobe values and transfer counts.
module tb_channel_hop_sequencer;
   localparam int W = 16, PW = 12, NH = 16, DW = 16, AW = 4;

   logic          i_clock = 1'b0, i_reset = 1'b1;
   logic [W-1:0]  i_inph = '0, i_quad = '0, o_inph, o_quad;
   logic          i_valid = 1'b0, i_ready = 1'b0, o_valid, o_ready;
   logic [PW-1:0] o_phase_inc, i_tbl_data = '0;
   logic          o_phase_inc_valid, i_tbl_we = 1'b0, i_start = 1'b0, i_stop = 1'b0, o_busy;
   logic [AW-1:0] i_tbl_addr = '0, o_hop_index;
   logic [AW:0]   i_hop_count = '0;
   logic [DW-1:0] i_dwell = '0;

   channel_hop_sequencer #(.WIDTH(W), .PHASE_WIDTH(PW), .NUM_HOPS(NH), .DWELL_WIDTH(DW)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_inph(i_inph), .i_quad(i_quad),
      .i_valid(i_valid), .o_ready(o_ready), .o_inph(o_inph), .o_quad(o_quad),
      .o_valid(o_valid), .i_ready(i_ready), .o_phase_inc(o_phase_inc),
      .o_phase_inc_valid(o_phase_inc_valid), .i_tbl_we(i_tbl_we), .i_tbl_addr(i_tbl_addr),
      .i_tbl_data(i_tbl_data), .i_hop_count(i_hop_count), .i_dwell(i_dwell),
      .i_start(i_start), .i_stop(i_stop), .o_busy(o_busy), .o_hop_index(o_hop_index));

   always #5 i_clock = ~i_clock;

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Abstract model: mode 0=idle, 1=loading, 2=streaming
   int            m_mode = 0, m_hop = 0, m_cnt = 0, m_hc = 1, m_dw = 1;
   logic [PW-1:0] m_inc;
   logic [PW-1:0] m_tbl [NH];

   always @(posedge i_clock) begin
      int nh;
      if (i_reset) begin
         m_mode <= 0; m_hop <= 0; m_cnt <= 0; m_inc <= '0;
      end else begin
         case (m_mode)
            0: if (i_start && !i_stop) begin
                  m_hc   <= (int'(i_hop_count) == 0) ? 1 : (int'(i_hop_count) > NH ? NH : int'(i_hop_count));
                  m_dw   <= (int'(i_dwell) == 0) ? 1 : int'(i_dwell);
                  m_hop  <= 0; m_cnt <= 0; m_inc <= m_tbl[0]; m_mode <= 1;
               end
            1: if (i_stop) begin m_mode <= 0; m_hop <= 0; m_cnt <= 0; end
               else m_mode <= 2;
            default: if (i_stop) begin m_mode <= 0; m_hop <= 0; m_cnt <= 0; end
               else if (i_valid && i_ready) begin
                  if (m_cnt + 1 == m_dw) begin
                     nh = (m_hop + 1) % m_hc;
                     m_hop <= nh; m_cnt <= 0; m_inc <= m_tbl[nh]; m_mode <= 1;
                  end else m_cnt <= m_cnt + 1;
               end
         endcase
         if (i_tbl_we) m_tbl[i_tbl_addr] <= i_tbl_data;
      end
   end

   // Per-cycle compare plus strobe/transfer monitor
   logic [PW-1:0] strobe_q[$];
   int            gapx_q[$], gapc_q[$];
   logic [W-1:0]  xfer_q[$];
   int            xf_since = 0, cyc_since = 0, n_vld = 0, n_rdy = 0;
   logic          last_xfer = 1'b0;

   always @(negedge i_clock) begin
      logic ev;
      ev = !i_reset && m_mode == 2 && i_valid;
      check("o_valid", o_valid, ev);
      check("o_ready", o_ready, !i_reset && m_mode == 2 && i_ready);
      check("strobe", o_phase_inc_valid, !i_reset && m_mode == 1);
      check("phase_inc", o_phase_inc, i_reset ? 0 : m_inc);
      check("o_busy", o_busy, !i_reset && m_mode != 0);
      check("hop_index", o_hop_index, i_reset ? 0 : m_hop);
      if (ev) begin
         check("o_inph", o_inph, i_inph);
         check("o_quad", o_quad, i_quad);
      end
      if (o_phase_inc_valid) begin
         strobe_q.push_back(o_phase_inc);
         gapx_q.push_back(xf_since);
         gapc_q.push_back(cyc_since);
         xf_since  <= 0;
         cyc_since <= 1;
      end else begin
         cyc_since <= cyc_since + 1;
         xf_since  <= xf_since + ((o_valid && i_ready) ? 1 : 0);
      end
      if (o_valid && i_ready) xfer_q.push_back(o_inph);
      last_xfer <= o_valid && i_ready;
      n_vld     <= n_vld + (o_valid ? 1 : 0);
      n_rdy     <= n_rdy + (o_ready ? 1 : 0);
   end

   task automatic tick();
      @(posedge i_clock); #1;
   endtask

   task automatic clear_mon();
      strobe_q.delete(); gapx_q.delete(); gapc_q.delete(); xfer_q.delete();
   endtask

   task automatic wr(input int a, input int d);
      i_tbl_we = 1'b1; i_tbl_addr = AW'(a); i_tbl_data = PW'(d);
      tick();
      i_tbl_we = 1'b0;
   endtask

   task automatic start_seq(input int hc, input int dw);
      i_hop_count = (AW+1)'(hc); i_dwell = DW'(dw); i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic stop_seq();
      i_valid = 1'b0; i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      tick();
   endtask

   task automatic wait_strobes(input int n, input int budget);
      for (int c = 0; c < budget && strobe_q.size() < n; c++) tick();
      check("strobe_wait", strobe_q.size() >= n, 1);
   endtask

   initial begin
      int bad;
      // reset state
      tick(); tick();
      check("rst_busy", o_busy, 0);
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 0);
      check("rst_strobe", o_phase_inc_valid, 0);
      check("rst_inc", o_phase_inc, 0);
      check("rst_hop", o_hop_index, 0);
      i_reset = 1'b0;
      for (int a = 0; a < NH; a++) wr(a, 'h100 + a);

      // idle with traffic: nothing passes, nothing strobes
      clear_mon();
      n_vld = 0; n_rdy = 0;
      i_valid = 1'b1; i_ready = 1'b1;
      repeat (100) tick();
      check("idle_valid_cnt", n_vld, 0);
      check("idle_ready_cnt", n_rdy, 0);
      check("idle_strobes", strobe_q.size(), 0);
      i_valid = 1'b0;

      // 3 hops, dwell 4, continuous flow
      wr(0, 'h010); wr(1, 'h020); wr(2, 'h030);
      clear_mon();
      i_valid = 1'b1;
      start_seq(3, 4);
      wait_strobes(4, 60);
      if (strobe_q.size() >= 4) begin
         check("h3_s0", strobe_q[0], 'h010);
         check("h3_s1", strobe_q[1], 'h020);
         check("h3_s2", strobe_q[2], 'h030);
         check("h3_s3", strobe_q[3], 'h010);
         for (int k = 1; k < 4; k++) begin
            check("h3_xfers", gapx_q[k], 4);
            check("h3_cycles", gapc_q[k], 5);
         end
      end
      stop_seq();

      // 2 hops, dwell 3, ready toggling, incrementing I/Q
      wr(0, 'h100); wr(1, 'h200);
      clear_mon();
      i_inph = '0; i_quad = '1; i_valid = 1'b1; i_ready = 1'b1;
      start_seq(2, 3);
      for (int c = 0; c < 200 && strobe_q.size() < 5; c++) begin
         tick();
         if (last_xfer) i_inph = i_inph + 1'b1;
         i_quad  = ~i_inph;
         i_ready = ~i_ready;
      end
      check("tg_strobes", strobe_q.size() >= 5, 1);
      if (strobe_q.size() >= 5) begin
         check("tg_s1", strobe_q[1], 'h200);
         check("tg_s4", strobe_q[4], 'h100);
         for (int k = 1; k < 5; k++) check("tg_xfers", gapx_q[k], 3);
      end
      if (xfer_q.size() > 0) check("tg_first", xfer_q[0], 0);
      bad = 0;
      foreach (xfer_q[k]) if (xfer_q[k] != W'(k)) bad++;
      check("tg_iq_seq", bad, 0);
      i_ready = 1'b1;
      stop_seq();

      // degenerate dwell=0, hop_count=0
      wr(0, 'h7FF);
      clear_mon();
      i_valid = 1'b1;
      start_seq(0, 0);
      wait_strobes(4, 40);
      if (strobe_q.size() >= 4)
         for (int k = 0; k < 4; k++) begin
            check("deg_val", strobe_q[k], 'h7FF);
            if (k > 0) begin
               check("deg_xfers", gapx_q[k], 1);
               check("deg_cycles", gapc_q[k], 2);
            end
         end
      stop_seq();

      // stop after 2 of 4 transfers, then restart
      wr(0, 'h0AB); wr(1, 'h0CD);
      clear_mon();
      start_seq(2, 4);
      wait_strobes(1, 10);
      i_valid = 1'b1;
      tick(); tick();
      i_valid = 1'b0; i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      check("stop_busy", o_busy, 0);
      check("stop_hop", o_hop_index, 0);
      check("stop_xfers", xf_since, 2);
      clear_mon();
      start_seq(2, 4);
      wait_strobes(1, 10);
      if (strobe_q.size() >= 1) check("restart_val", strobe_q[0], 'h0AB);

      // reset mid-run, table survives
      i_valid = 1'b1;
      wait_strobes(2, 30);
      check("mid_hop", o_hop_index, 1);
      bad = strobe_q.size();
      i_reset = 1'b1;
      tick();
      check("rst_run_inc", o_phase_inc, 0);
      check("rst_run_busy", o_busy, 0);
      tick(); tick();
      check("rst_no_strobe", strobe_q.size(), bad);
      i_reset = 1'b0;
      i_valid = 1'b0;
      tick();
      check("post_rst_strobes", strobe_q.size(), bad);
      clear_mon();
      start_seq(2, 4);
      wait_strobes(1, 10);
      if (strobe_q.size() >= 1) check("post_rst_val", strobe_q[0], 'h0AB);
      stop_seq();

      // hop_count above NUM_HOPS clamps; dwell 1
      clear_mon();
      i_valid = 1'b1;
      start_seq(20, 1);
      wait_strobes(17, 80);
      if (strobe_q.size() >= 17) begin
         check("clamp_s15", strobe_q[15], 'h10F);
         check("clamp_wrap", strobe_q[16], 'h0AB);
      end
      stop_seq();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/channel_hop_sequencer.md
CHANNEL_HOP_SEQUENCER -- requirements
Module: channel_hop_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: I/Q sample width in bits.
REQ-002 Parameter PHASE_WIDTH, default 12: phase-increment width; matches the downstream modulator increment port.
REQ-003 Parameter NUM_HOPS, default 16: hop-table depth, a power of two; AW = log2(NUM_HOPS).
REQ-004 Parameter DWELL_WIDTH, default 16: dwell-counter width.
REQ-005 i_clock  in  1  clock; all logic rising-edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_inph, i_quad  in  WIDTH each  upstream sample.
REQ-008 i_valid  in  1  upstream sample valid.
REQ-009 o_ready  out  1  ready to upstream.
REQ-010 o_inph, o_quad  out  WIDTH each  sample to modulator.
REQ-011 o_valid  out  1  sample valid to modulator.
REQ-012 i_ready  in  1  modulator ready.
REQ-013 o_phase_inc  out  PHASE_WIDTH  phase increment to modulator.
REQ-014 o_phase_inc_valid  out  1  one-cycle increment-load strobe.
REQ-015 i_tbl_we  in  1, i_tbl_addr  in  AW, i_tbl_data  in  PHASE_WIDTH: hop-table write port.
REQ-016 i_hop_count  in  AW+1  number of active hops, 1..NUM_HOPS.
REQ-017 i_dwell  in  DWELL_WIDTH  samples transferred per hop.
REQ-018 i_start  in  1, i_stop  in  1: sequence control pulses.
REQ-019 o_busy  out  1  high when state is not IDLE.
REQ-020 o_hop_index  out  AW  index of the current hop.

Function
REQ-021 The FSM SHALL have three states: IDLE, LOAD and RUN.
REQ-022 IDLE with i_start=1 and i_stop=0 SHALL latch i_hop_count and i_dwell, set hop index 0, and go to LOAD.
REQ-023 A latched hop_count of 0 SHALL be treated as 1; a latched hop_count above NUM_HOPS SHALL be clamped to NUM_HOPS; a latched dwell of 0 SHALL be treated as 1.
REQ-024 LOAD SHALL last exactly one cycle, drive o_phase_inc_valid=1 with o_phase_inc equal to table[hop index], then go to RUN.
REQ-025 The table read SHALL be registered, with read-before-write: a write to the loaded address in the LOAD-entry cycle SHALL take effect at the next visit to that address.
REQ-026 In RUN the stream SHALL pass through combinationally with zero latency: o_inph=i_inph, o_quad=i_quad, o_valid=i_valid, o_ready=i_ready.
REQ-027 In IDLE and LOAD the stream SHALL be stalled: o_valid=0 and o_ready=0.
REQ-028 A transfer SHALL be defined as o_valid and i_ready both high in the same cycle; the dwell counter SHALL count transfers only.
REQ-029 On the transfer that brings the count to dwell, the counter SHALL clear, the hop index SHALL advance modulo hop_count, and the FSM SHALL go to LOAD.
REQ-030 The sample following a hop boundary SHALL be transferred only after that hop's o_phase_inc_valid strobe.
REQ-031 i_stop=1 in LOAD or RUN SHALL force IDLE on the next cycle, clear the counter and hop index, and allow any transfer in that same cycle to complete.
REQ-032 i_start while busy SHALL be ignored; i_start and i_stop together in IDLE SHALL leave the block in IDLE.
REQ-033 Table writes SHALL be accepted in every state, outside reset.
REQ-034 o_phase_inc SHALL hold its last loaded value outside LOAD.

Reset
REQ-035 While i_reset=1: state=IDLE, o_phase_inc_valid=0, o_phase_inc=0, o_valid=0, o_ready=0, o_busy=0, o_hop_index=0, dwell counter=0.
REQ-036 Reset SHALL NOT clear the hop table.
REQ-037 Reset asserted mid-RUN SHALL abort the sequence with no further o_phase_inc_valid strobe.

Verification
REQ-038 No i_start, i_valid=1, i_ready=1 for 100 cycles -> o_valid=0, o_ready=0, zero strobes.
REQ-039 Table {0x010,0x020,0x030}, hop_count=3, dwell=4, continuous valid/ready -> strobes 0x010,0x020,0x030,0x010; exactly 4 transfers between consecutive strobes; one stall cycle at each boundary.
REQ-040 hop_count=2, dwell=3, i_ready toggling every cycle -> still exactly 3 transfers per hop; no sample dropped or duplicated (check with an incrementing I/Q pattern).
REQ-041 dwell=0, hop_count=0, table[0]=0x7FF -> a 0x7FF strobe before every single transfer.
REQ-042 i_stop after 2 of 4 transfers -> IDLE next cycle and o_hop_index=0; the next i_start reloads table[0].
REQ-043 i_reset mid-RUN, then i_start -> first strobe carries table[0] with the previously written table contents intact.
